// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and PC-source encodings for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic {RUN, MEM_WAIT} state_t;
  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: datapath <-> hazard controller signal bundle
interface pipe_hazard_ctrl_if;
  logic [4:0] rs_IFID_HC;
  logic [4:0] rt_IFID_HC;
  logic       MemRead_IDEX_HC;
  logic [4:0] rt_IDEX_HC;
  logic       branch_BF2_HC;
  logic       zf_BF2_HC;
  logic       jump_BF2_HC;
  logic       MemRead_BF2_HC;
  logic       MemWrite_BF2_HC;
  logic       mem_ack_HC;
  logic       pc_we_HC;
  logic [1:0] pc_sel_HC;
  logic       en_IFID_HC, en_IDEX_HC, en_EXMEM_HC, en_MEMWB_HC;
  logic       fl_IFID_HC, fl_IDEX_HC, fl_EXMEM_HC, fl_MEMWB_HC;
  logic       mem_req_HC;
  logic       mem_err_HC;
  modport master (
    output rs_IFID_HC, rt_IFID_HC, MemRead_IDEX_HC, rt_IDEX_HC, branch_BF2_HC, zf_BF2_HC,
           jump_BF2_HC, MemRead_BF2_HC, MemWrite_BF2_HC, mem_ack_HC,
    input  pc_we_HC, pc_sel_HC, en_IFID_HC, en_IDEX_HC, en_EXMEM_HC, en_MEMWB_HC,
           fl_IFID_HC, fl_IDEX_HC, fl_EXMEM_HC, fl_MEMWB_HC, mem_req_HC, mem_err_HC
  );
  modport slave (
    input  rs_IFID_HC, rt_IFID_HC, MemRead_IDEX_HC, rt_IDEX_HC, branch_BF2_HC, zf_BF2_HC,
           jump_BF2_HC, MemRead_BF2_HC, MemWrite_BF2_HC, mem_ack_HC,
    output pc_we_HC, pc_sel_HC, en_IFID_HC, en_IDEX_HC, en_EXMEM_HC, en_MEMWB_HC,
           fl_IFID_HC, fl_IDEX_HC, fl_EXMEM_HC, fl_MEMWB_HC, mem_req_HC, mem_err_HC
  );
endinterface

// File: rtl/pipe_wait_timer.sv
// pipe_wait_timer: counts memory-wait freeze cycles and flags the timeout limit
module pipe_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [CNT_W-1:0] cnt;
  // clear wins over increment so a released wait always restarts from zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  assign expired = cnt == CNT_W'(MEM_TIMEOUT);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: buffer enable/flush and PC control for the 5-stage pipeline (HC_PERF_CNT_EN adds event counters)
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk_HC,
  input  logic rst_n_HC,
  pipe_hazard_ctrl_if.slave hc
`ifdef HC_PERF_CNT_EN
  ,
  output logic [31:0] cnt_ldstall_HC,
  output logic [31:0] cnt_memwait_HC,
  output logic [31:0] cnt_flush_HC
`endif
);
  import pipe_ctrl_pkg::*;
  state_t state, state_nxt;
  logic mem_op, expired, freeze, redirect, ld_use, timeout;
  pipe_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk(clk_HC), .rst_n(rst_n_HC), .clr(!freeze), .inc(freeze), .expired(expired)
  );
  // state register plus the sticky timeout flag
  always_ff @(posedge clk_HC or negedge rst_n_HC)
    if (!rst_n_HC) begin
      state <= RUN;
      hc.mem_err_HC <= 1'b0;
    end else begin
      state <= state_nxt;
      if (timeout) hc.mem_err_HC <= 1'b1;
    end
  // hazard priority: memory wait, then redirect, then load-use; everything idles while in reset
  always_comb begin
    mem_op = hc.MemRead_BF2_HC | hc.MemWrite_BF2_HC;
    freeze = rst_n_HC & !hc.mem_ack_HC & (state == MEM_WAIT ? !expired : mem_op);
    timeout = state == MEM_WAIT & expired & !hc.mem_ack_HC;
    redirect = rst_n_HC & !freeze & (hc.jump_BF2_HC | (hc.branch_BF2_HC & hc.zf_BF2_HC));
    ld_use = rst_n_HC & !freeze & !redirect & hc.MemRead_IDEX_HC & (|hc.rt_IDEX_HC) &
             (hc.rt_IDEX_HC == hc.rs_IFID_HC | hc.rt_IDEX_HC == hc.rt_IFID_HC);
    state_nxt = freeze ? MEM_WAIT : RUN;
    hc.pc_we_HC = !(freeze | ld_use);
    hc.pc_sel_HC = !redirect ? PC_SEL_SEQ : hc.jump_BF2_HC ? PC_SEL_JMP : PC_SEL_BR;
    hc.en_IFID_HC = !(freeze | ld_use);
    hc.en_IDEX_HC = !freeze;
    hc.en_EXMEM_HC = !freeze;
    hc.en_MEMWB_HC = 1'b1;
    hc.fl_IFID_HC = redirect;
    hc.fl_IDEX_HC = redirect | ld_use;
    hc.fl_EXMEM_HC = redirect;
    hc.fl_MEMWB_HC = freeze;
    hc.mem_req_HC = mem_op & rst_n_HC;
  end
`ifdef HC_PERF_CNT_EN
  // free-running event counters, wrapping naturally at 2^32
  always_ff @(posedge clk_HC or negedge rst_n_HC)
    if (!rst_n_HC) begin
      cnt_ldstall_HC <= '0;
      cnt_memwait_HC <= '0;
      cnt_flush_HC <= '0;
    end else begin
      cnt_ldstall_HC <= cnt_ldstall_HC + 32'(ld_use);
      cnt_memwait_HC <= cnt_memwait_HC + 32'(freeze);
      cnt_flush_HC <= cnt_flush_HC + 32'(redirect);
    end
`endif
endmodule
